// File: rtl/wasm_pkg.sv
// ---------------------------------------------------------------------------
// wasm_pkg
//
// Purpose:
//   Shared definitions for the WebAssembly relational execution unit:
//   compare opcode encodings, trap codes, the control FSM state type and a
//   small helper that tells legal opcodes apart from reserved ones.
//
// Contents:
//   OP_*          4-bit compare opcodes (codes 11..15 are reserved/invalid)
//   TRAP_*        trap codes reported on the sticky trap output (0 = none)
//   cmp_state_e   control FSM states of wasm_cmp_unit
//   is_valid_op   1 when an opcode is one of the defined compares
// ---------------------------------------------------------------------------
package wasm_pkg;

  // Compare opcodes. Operand order is "a op b", where a is the deeper
  // (first-pushed) stack entry and b is the top of stack.
  localparam logic [3:0] OP_EQZ  = 4'd0;
  localparam logic [3:0] OP_EQ   = 4'd1;
  localparam logic [3:0] OP_NE   = 4'd2;
  localparam logic [3:0] OP_LT_S = 4'd3;
  localparam logic [3:0] OP_LT_U = 4'd4;
  localparam logic [3:0] OP_GT_S = 4'd5;
  localparam logic [3:0] OP_GT_U = 4'd6;
  localparam logic [3:0] OP_LE_S = 4'd7;
  localparam logic [3:0] OP_LE_U = 4'd8;
  localparam logic [3:0] OP_GE_S = 4'd9;
  localparam logic [3:0] OP_GE_U = 4'd10;

  // Trap codes. Traps are fatal: once raised they stay until reset.
  localparam int unsigned TRAP_NONE            = 0;
  localparam int unsigned TRAP_STACK_UNDERFLOW = 1;
  localparam int unsigned TRAP_STACK_OVERFLOW  = 2;
  localparam int unsigned TRAP_INVALID_OP      = 3;

  // Control FSM states. ST_EXEC is skipped by the fast build, which folds
  // the evaluation into the last pop cycle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP_B = 3'd1,
    ST_POP_A = 3'd2,
    ST_EXEC  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_TRAP  = 3'd5
  } cmp_state_e;

  // Defined opcodes form the contiguous range OP_EQZ..OP_GE_U.
  function automatic logic is_valid_op(input logic [3:0] op);
    return (op <= OP_GE_U);
  endfunction

endpackage

// File: rtl/wasm_cmp_unit_if.sv
// ---------------------------------------------------------------------------
// wasm_cmp_unit_if
//
// Purpose:
//   Bundles the command handshake and the operand stack bus of the
//   relational execution unit.
//
// Parameters:
//   WIDTH   operand stack data width (32 or 64)
//   TRAP_W  width of the trap code
//
// Signals:
//   start, op, is64                 command from the core sequencer
//   busy, done, trap                status back to the sequencer
//   stack_top, stack_empty,
//   stack_full                      operand stack view (from the stack)
//   stack_pop, stack_push,
//   stack_push_data                 operand stack requests (to the stack)
//
// Modports:
//   master  sequencer/stack side (drives command and stack view)
//   slave   execution unit side
// ---------------------------------------------------------------------------
interface wasm_cmp_unit_if #(
  parameter int WIDTH  = 64,
  parameter int TRAP_W = 4
);

  logic              start;
  logic [3:0]        op;
  logic              is64;
  logic              busy;
  logic              done;
  logic [TRAP_W-1:0] trap;
  logic [WIDTH-1:0]  stack_top;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_pop;
  logic              stack_push;
  logic [WIDTH-1:0]  stack_push_data;

  modport master (
    output start, op, is64, stack_top, stack_empty, stack_full,
    input  busy, done, trap, stack_pop, stack_push, stack_push_data
  );

  modport slave (
    input  start, op, is64, stack_top, stack_empty, stack_full,
    output busy, done, trap, stack_pop, stack_push, stack_push_data
  );

endinterface

// File: rtl/wasm_cmp_core.sv
// ---------------------------------------------------------------------------
// wasm_cmp_core
//
// Purpose:
//   Purely combinational relational evaluator shared by the normal and the
//   fast build of wasm_cmp_unit. Computes "a op b" (or "b == 0" for EQZ)
//   at 32- or 64-bit width and returns a single result bit.
//
// Parameters:
//   WIDTH   operand width (32 or 64)
//
// Ports:
//   a       in  WIDTH  deeper operand
//   b       in  WIDTH  top-of-stack operand
//   op      in  4      compare opcode (wasm_pkg::OP_*)
//   is64    in  1      1 = full 64-bit compare, 0 = compare bits [31:0]
//   result  out 1      comparison outcome; 0 for reserved opcodes
// ---------------------------------------------------------------------------
module wasm_cmp_core
  import wasm_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             is64,
  output logic             result
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] a_m;
  logic [63:0] b_m;
  logic [63:0] sign_flip;
  logic [63:0] a_key;
  logic [63:0] b_key;
  logic        eq;
  logic        lt_u;
  logic        lt_s;

  // Operands are widened to 64 bits and, for i32, the upper half is cleared
  // so the garbage above bit 31 never influences the outcome. A signed
  // compare is done as an unsigned compare after inverting the sign bit of
  // the active width, which keeps a single magnitude comparator per flavour.
  always_comb begin
    a_ext = 64'(a);
    b_ext = 64'(b);
    if (is64) begin
      a_m       = a_ext;
      b_m       = b_ext;
      sign_flip = 64'h8000_0000_0000_0000;
    end else begin
      a_m       = {32'h0, a_ext[31:0]};
      b_m       = {32'h0, b_ext[31:0]};
      sign_flip = 64'h0000_0000_8000_0000;
    end
    a_key = a_m ^ sign_flip;
    b_key = b_m ^ sign_flip;
    eq    = (a_m == b_m);
    lt_u  = (a_m < b_m);
    lt_s  = (a_key < b_key);
  end

  // Every relation is derived from eq / lt so that the greater-than and
  // inclusive forms cannot drift from the strict less-than paths.
  always_comb begin
    result = 1'b0;
    case (op)
      OP_EQZ:  result = (b_m == 64'h0);
      OP_EQ:   result = eq;
      OP_NE:   result = !eq;
      OP_LT_S: result = lt_s;
      OP_LT_U: result = lt_u;
      OP_GT_S: result = !lt_s && !eq;
      OP_GT_U: result = !lt_u && !eq;
      OP_LE_S: result = lt_s || eq;
      OP_LE_U: result = lt_u || eq;
      OP_GE_S: result = !lt_s;
      OP_GE_U: result = !lt_u;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/wasm_cmp_unit.sv
// ---------------------------------------------------------------------------
// wasm_cmp_unit
//
// Purpose:
//   Multi-cycle relational execution unit of the WebAssembly core. Pops one
//   (EQZ) or two operands from the operand stack, evaluates an i32/i64
//   eqz/eq/ne/lt/gt/le/ge compare (signed or unsigned) and pushes the i32
//   result 0/1 back onto the stack. Stack underflow, stack overflow and
//   reserved opcodes raise a sticky trap that only reset clears.
//
// Parameters:
//   WIDTH   operand stack data width (32 or 64)
//   TRAP_W  width of the trap code output
//
// Ports:
//   clk     in  1  system clock
//   reset   in  1  asynchronous, active-low reset
//   bus     wasm_cmp_unit_if.slave:
//             start/op/is64 in     command, sampled only in IDLE
//             busy out             high outside IDLE and TRAP
//             done out             one-cycle pulse with the result push
//             trap out             sticky trap code, 0 = none
//             stack_top/empty/full in   operand stack view
//             stack_pop/push out        stack requests for this edge
//             stack_push_data out       zero-extended result bit
//
// Build option:
//   WASM_CMP_FAST_EN  when defined, the EXEC cycle is dropped: the result is
//                     evaluated from stack_top during the last pop and
//                     registered there (binary push in cycle 3, EQZ in 2).
//                     Undefined: binary push in cycle 4, EQZ in cycle 3.
// ---------------------------------------------------------------------------
module wasm_cmp_unit
  import wasm_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int TRAP_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  wasm_cmp_unit_if.slave bus
);

`ifdef WASM_CMP_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  cmp_state_e        state_q;
  cmp_state_e        state_d;
  logic [TRAP_W-1:0] trap_q;
  logic [TRAP_W-1:0] trap_d;
  logic [3:0]        op_q;
  logic              is64_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              result_q;

  logic              pop;
  logic              push;
  logic              capture_result;
  logic [WIDTH-1:0]  core_a;
  logic [WIDTH-1:0]  core_b;
  logic              core_result;

  // In the fast build the operand still sitting on the stack is fed straight
  // into the evaluator during its pop cycle, so the result can be registered
  // on the same edge that consumes it. In the normal build the evaluator only
  // ever sees the latched operands.
  always_comb begin
    core_a = a_q;
    core_b = b_q;
    if (FAST_EN && (state_q == ST_POP_A)) begin
      core_a = bus.stack_top;
    end
    if (FAST_EN && (state_q == ST_POP_B)) begin
      core_b = bus.stack_top;
    end
  end

  wasm_cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (core_a),
    .b      (core_b),
    .op     (op_q),
    .is64   (is64_q),
    .result (core_result)
  );

  // The result register loads in EXEC (normal build) or on the final
  // successful pop (fast build): POP_B for EQZ, POP_A for binary ops.
  always_comb begin
    if (FAST_EN) begin
      capture_result = pop && ((state_q == ST_POP_A) || (op_q == OP_EQZ));
    end else begin
      capture_result = (state_q == ST_EXEC);
    end
  end

  // Next-state and stack request logic. Empty is only looked at while
  // popping and full only while pushing, so an inconsistent empty+full
  // stack view resolves by the state we are in.
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (!is_valid_op(bus.op)) begin
            state_d = ST_TRAP;
            trap_d  = TRAP_W'(TRAP_INVALID_OP);
          end else begin
            state_d = ST_POP_B;
          end
        end
      end
      ST_POP_B: begin
        if (bus.stack_empty) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_W'(TRAP_STACK_UNDERFLOW);
        end else begin
          pop = 1'b1;
          if (op_q == OP_EQZ) begin
            state_d = FAST_EN ? ST_PUSH : ST_EXEC;
          end else begin
            state_d = ST_POP_A;
          end
        end
      end
      ST_POP_A: begin
        // b has already been consumed here; a trap is fatal anyway.
        if (bus.stack_empty) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_W'(TRAP_STACK_UNDERFLOW);
        end else begin
          pop     = 1'b1;
          state_d = FAST_EN ? ST_PUSH : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (bus.stack_full) begin
          state_d = ST_TRAP;
          trap_d  = TRAP_W'(TRAP_STACK_OVERFLOW);
        end else begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, trap and datapath registers. Reset abandons any operation in
  // flight; since push is decoded from the state, no push can follow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      trap_q   <= TRAP_W'(TRAP_NONE);
      op_q     <= 4'h0;
      is64_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      if ((state_q == ST_IDLE) && bus.start) begin
        op_q   <= bus.op;
        is64_q <= (WIDTH == 64) ? bus.is64 : 1'b0;
      end
      if ((state_q == ST_POP_B) && pop) begin
        b_q <= bus.stack_top;
      end
      if ((state_q == ST_POP_A) && pop) begin
        a_q <= bus.stack_top;
      end
      if (capture_result) begin
        result_q <= core_result;
      end
    end
  end

  assign bus.busy            = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign bus.done            = push;
  assign bus.stack_pop       = pop;
  assign bus.stack_push      = push;
  assign bus.trap            = trap_q;
  assign bus.stack_push_data = {{(WIDTH-1){1'b0}}, result_q};

endmodule

// File: doc/wasm_cmp_unit.md
Name: wasm_cmp_unit

Overview:
- Multi-cycle relational execution unit for the WebAssembly core.
- Executes i32/i64 eqz, eq, ne, lt, gt, le and ge, in signed and unsigned forms.
- Pops its operands from the operand stack, computes the result, and pushes an i32 0/1 back.
- Replaces the per-opcode single-width compare paths; width and stack data width are parametrised.

Parameters:
- WIDTH, 64, operand stack data width; legal values are 32 or 64.
- TRAP_W, 4, width of the trap code output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to execute; sampled only in IDLE.
- op  in  4  compare opcode, encoded per the package constants.
- is64  in  1  1 = i64 operation, 0 = i32 operation; forced to 0 when WIDTH=32.
- busy  out  1  high in every state except IDLE and TRAP.
- done  out  1  one-cycle pulse, coincident with the result push.
- trap  out  TRAP_W  sticky trap code; 0 = none.
- stack_top  in  WIDTH  current top-of-stack value, presented combinationally.
- stack_empty  in  1  operand stack is empty.
- stack_full  in  1  operand stack is full.
- stack_pop  out  1  consume the top entry at this clock edge.
- stack_push  out  1  push stack_push_data at this clock edge.
- stack_push_data  out  WIDTH  result, zero-extended 0 or 1.

Behaviour:
- Reset (asynchronous, active-low):
  - state goes to IDLE.
  - busy, done, stack_pop and stack_push go to 0.
  - trap goes to 0.
  - stack_push_data goes to 0.
  - Latched operands go to 0.
  - An in-flight operation is abandoned; no push occurs.
- IDLE:
  - When start=1, latch op and is64, then go to POP_B.
  - If op is not a defined opcode, go to TRAP with TRAP_INVALID_OP; the stack is untouched.
- POP_B:
  - If stack_empty, go to TRAP with TRAP_STACK_UNDERFLOW.
  - Otherwise latch b=stack_top and assert stack_pop for this cycle.
  - For EQZ, go next to EXEC; for all other ops, go to POP_A.
- POP_A:
  - If stack_empty, go to TRAP with TRAP_STACK_UNDERFLOW. b is already consumed; this is acceptable because traps are fatal.
  - Otherwise latch a=stack_top, assert stack_pop, and go to EXEC.
- EXEC:
  - Evaluate "a op b" (for EQZ: b==0) into a registered result bit.
  - Go to PUSH.
- PUSH:
  - If stack_full, go to TRAP with TRAP_STACK_OVERFLOW.
  - Otherwise assert stack_push and done, then return to IDLE.
- TRAP:
  - Terminal state; trap holds its code and start is ignored.
  - Leaves only via reset.
- Latency (binary ops): start sampled at edge 0. The pops occur in cycles 1 and 2, EXEC in cycle 3, push/done in cycle 4. The earliest next start is sampled in cycle 5.
- Latency (EQZ): one cycle shorter; push occurs in cycle 3.
- Width rules:
  - With is64=0, only bits [31:0] are compared and the signed compare uses bit 31.
  - With is64=1, the full 64 bits are compared.
  - Upper bits of i32 operands are ignored.
- Operand order: a is the deeper (first-pushed) operand and b is the top, so lt_s means a<b.
- start arriving while busy is ignored; there is no queueing.
- Simultaneous stack_empty and stack_full (illegal stack state): empty is checked in the POP states and full only in PUSH.

Optional Feature:
- Macro: WASM_CMP_FAST_EN.
- Defined: the EXEC state is removed. The result is computed combinationally from stack_top and b in the last POP state and registered there. Binary ops push in cycle 3; EQZ pushes in cycle 2.
- Undefined: the 4-cycle binary / 3-cycle EQZ schedule above applies.
- Trap behaviour is identical in both builds.

Decomposition:
- Shared package wasm_pkg holds:
  - Opcode constants: OP_EQZ=0, OP_EQ=1, OP_NE=2, OP_LT_S=3, OP_LT_U=4, OP_GT_S=5, OP_GT_U=6, OP_LE_S=7, OP_LE_U=8, OP_GE_S=9, OP_GE_U=10. Codes 11-15 are invalid.
  - Trap codes: TRAP_NONE=0, TRAP_STACK_UNDERFLOW=1, TRAP_STACK_OVERFLOW=2, TRAP_INVALID_OP=3.
  - The state enum.
- One combinational sub-module, wasm_cmp_core (a, b, op, is64 -> result bit), is shared by both builds.

Test Plan:
- i64.ne: stack [1, 2] (top 2), op=NE, is64=1, start -> push 1 at cycle 4, done pulse, two pops, trap=0.
- i32.lt_s vs lt_u: stack [0xFFFFFFFF, 1] -> LT_S pushes 1, LT_U pushes 0. i64 GE_U with [0x8000000000000000, 1] -> pushes 1.
- i32 upper-bit masking: stack [0xAAAA_0000_0000_0005, 0x5555_0000_0000_0005], op=EQ, is64=0 -> pushes 1. The same stack with is64=1 pushes 0.
- Underflow: stack of depth 1, op=EQ -> one pop, then trap=1, busy=0. Subsequent starts are ignored until reset; after reset, trap=0.
- Invalid op: op=12 -> trap=3 on the cycle after start, with no stack_pop.
- Reset mid-op: assert reset in cycle 3 of an EQ -> no push, all outputs 0 asynchronously. A new EQZ on [0] after release pushes 1 at cycle 3 (cycle 2 with WASM_CMP_FAST_EN).
